// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1080p60 raster constants and the timing bundle shared with downstream stages
package vga_timing_pkg;
    localparam int H_ACTIVE = 1920;
    localparam int H_FP     = 88;
    localparam int H_SYNC   = 44;
    localparam int H_BP     = 148;
    localparam int V_ACTIVE = 1080;
    localparam int V_FP     = 4;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 36;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = 12;
    localparam int Y_W      = 11;
    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           de;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } vga_timing_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing outputs from the generator to its consumers
interface vga_timing_gen_if;
    import vga_timing_pkg::*;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           frame_start;
    logic           line_start;
    modport master (output hsync, vsync, de, x, y, frame_start, line_start);
    modport slave  (input  hsync, vsync, de, x, y, frame_start, line_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter for one raster axis with region decodes
module vga_axis_counter #(
    parameter int TOTAL = 2200,
    parameter int ACT   = 1920,
    parameter int FP    = 88,
    parameter int SYNC  = 44,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         in_sync
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] A_END = W'(ACT);
    localparam logic [W-1:0] S_BEG = W'(ACT + FP);
    localparam logic [W-1:0] S_END = W'(ACT + FP + SYNC);
    logic [W-1:0] cnt_d, cnt_q;
    always_comb begin
        cnt_d = en ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt     = cnt_q;
    assign wrap    = en && (cnt_q == LAST);
    assign active  = cnt_q < A_END;
    assign in_sync = (cnt_q >= S_BEG) && (cnt_q < S_END);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator with registered sync, enable and coordinates
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic              clk_pix,
    input  logic              rst,
    vga_timing_gen_if.master  vo
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap;
    vga_axis_counter #(.TOTAL(HT), .ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .W(X_W)) u_h (
        .clk(clk_pix), .rst(rst), .en(1'b1),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .in_sync(h_sync)
    );
    vga_axis_counter #(.TOTAL(VT), .ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .W(Y_W)) u_v (
        .clk(clk_pix), .rst(rst), .en(h_wrap),
        .cnt(v_cnt), .wrap(unused_v_wrap), .active(v_act), .in_sync(v_sync)
    );
    vga_timing_t t_d, t_q;
    logic fs_d, fs_q, ls_d, ls_q;
    always_comb begin
        t_d.hsync = h_sync ? HS_POL : !HS_POL;
        t_d.vsync = v_sync ? VS_POL : !VS_POL;
        t_d.de    = h_act && v_act;
        t_d.x     = t_d.de ? h_cnt : '0;
        t_d.y     = t_d.de ? v_cnt : '0;
        fs_d      = (h_cnt == '0) && (v_cnt == '0);
        ls_d      = h_cnt == '0;
    end
    // everything is registered so downstream sees one consistent pixel per clock
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            t_q  <= '{hsync: !HS_POL, vsync: !VS_POL, de: 1'b0, x: '0, y: '0};
            fs_q <= 1'b0;
            ls_q <= 1'b0;
        end else begin
            t_q  <= t_d;
            fs_q <= fs_d;
            ls_q <= ls_d;
        end
    end
    assign vo.hsync       = t_q.hsync;
    assign vo.vsync       = t_q.vsync;
    assign vo.de          = t_q.de;
    assign vo.x           = t_q.x;
    assign vo.y           = t_q.y;
    assign vo.frame_start = fs_q;
    assign vo.line_start  = ls_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded check of the 1080p generator plus a shrunk, inverted-polarity instance for frame-level timing
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif_s ();
    vga_timing_gen dut (.clk_pix(clk), .rst(rst), .vo(vif));
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_s (.clk_pix(clk), .rst(rst_s), .vo(vif_s));

    logic [27:0] ob, os;
    assign ob = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.frame_start, vif.line_start};
    assign os = {vif_s.hsync, vif_s.vsync, vif_s.de, vif_s.x, vif_s.y, vif_s.frame_start, vif_s.line_start};
    localparam logic [27:0] RST_B = 28'h0;
    localparam logic [27:0] RST_S = {2'b11, 26'h0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] model(input int h, input int v, input int ha, input int hf, input int hs,
                                          input int va, input int vf, input int vs, input bit hp, input bit vp);
        logic de, hsa, vsa;
        de  = (h < ha) && (v < va);
        hsa = (h >= ha + hf) && (h < ha + hf + hs);
        vsa = (v >= va + vf) && (v < va + vf + vs);
        return {hsa ? hp : !hp, vsa ? vp : !vp, de, de ? 12'(h) : 12'd0, de ? 11'(v) : 11'd0,
                (h == 0) && (v == 0), h == 0};
    endfunction

    // reference raster positions; expected outputs are queued on the edge that registers them
    logic [27:0] q_b[$], q_s[$];
    int mh = 0, mv = 0, sh = 0, sv = 0;
    always @(posedge clk) begin
        if (rst) begin
            q_b.delete();
            mh <= 0;
            mv <= 0;
        end else begin
            q_b.push_back(model(mh, mv, 1920, 88, 44, 1080, 4, 5, 1'b1, 1'b1));
            mh <= (mh == 2199) ? 0 : mh + 1;
            if (mh == 2199) mv <= (mv == 1124) ? 0 : mv + 1;
        end
        if (rst_s) begin
            q_s.delete();
            sh <= 0;
            sv <= 0;
        end else begin
            q_s.push_back(model(sh, sv, 16, 4, 3, 6, 2, 2, 1'b0, 1'b0));
            sh <= (sh == 27) ? 0 : sh + 1;
            if (sh == 27) sv <= (sv == 12) ? 0 : sv + 1;
        end
    end
    always @(negedge clk) begin
        if (rst) chk("rst_b", 32'(ob), 32'(RST_B));
        else if (q_b.size() > 0) chk("sb_b", 32'(ob), 32'(q_b.pop_front()));
        if (rst_s) chk("rst_s", 32'(os), 32'(RST_S));
        else if (q_s.size() > 0) chk("sb_s", 32'(os), 32'(q_s.pop_front()));
    end

    initial begin
        int off, de_n, last_x, rise, hs_n, n;
        int vs_edges, vs_n, li, vs_line, ymax;
        logic prev, cur, vs_ls;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        chk("first", {vif.frame_start, vif.line_start, vif.de, vif.x, vif.y}, {3'b111, 23'd0});
        @(negedge clk);
        chk("second", {vif.frame_start, vif.x}, {1'b0, 12'd1});
        de_n = 1; off = 1; last_x = 0; rise = -1; hs_n = 0; prev = 1'b0;
        while (!vif.line_start && off < 3000) begin
            if (vif.de) begin de_n++; last_x = vif.x; end
            if (vif.hsync && !prev) rise = off;
            if (vif.hsync) hs_n++;
            prev = vif.hsync;
            @(negedge clk);
            off++;
        end
        chk("line_period", off, 2200);
        chk("de_per_line", de_n, 1920);
        chk("last_x", last_x, 1919);
        chk("hs_rise", rise, 2008);
        chk("hs_width", hs_n, 44);
        n = 0;
        while (!(vif.de && vif.x == 12'd1000 && vif.y == 11'd2) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("seek_mid", 32'(n < 6000), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'(ob), 32'(RST_B));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("restart", {vif.frame_start, vif.line_start, vif.de, vif.x, vif.y}, {3'b111, 23'd0});
        n = 0;
        while (!vif_s.frame_start && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("seek_frame_s", 32'(n < 400), 1);
        chk("s_idle", {vif_s.hsync, vif_s.vsync}, 2'b11);
        off = 0; vs_edges = 0; vs_n = 0; hs_n = 0; de_n = 0; li = -1; vs_line = -1; vs_ls = 1'b0; ymax = 0; prev = 1'b0;
        do begin
            cur = !vif_s.vsync;
            if (vif_s.line_start) li++;
            if (cur && !prev) begin vs_edges++; vs_line = li; vs_ls = vif_s.line_start; end
            if (cur) vs_n++;
            if (!vif_s.hsync) hs_n++;
            if (vif_s.de) begin de_n++; if (vif_s.y > ymax) ymax = vif_s.y; end
            prev = cur;
            @(negedge clk);
            off++;
        end while (!vif_s.frame_start && off < 1000);
        chk("s_frame_period", off, 364);
        chk("s_vs_edges", vs_edges, 1);
        chk("s_vs_width", vs_n, 56);
        chk("s_hs_total", hs_n, 39);
        chk("s_de_count", de_n, 96);
        chk("s_ymax", ymax, 5);
        chk("s_vs_line", vs_line, 8);
        chk("s_vs_ls", 32'(vs_ls), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
